instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of instruction_memory and downstream-feeding decode.
- Owns the program counter and drives the word-aligned byte address into instruction memory. Memory returns the instruction combinationally in the same cycle.
- Captures {pc, instruction} pairs into a small fetch queue. Presents them to decode over a valid/ready handshake.
- Branch/jump redirects from execute flush the queue and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FIFO_DEPTH, 2: fetch queue entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- rst_n  in  1  Reset. Asynchronous, active-low.
- imem_addr  out  32  Byte address to instruction memory; always equals the current PC register.
- imem_instr  in  32  Instruction returned combinationally for imem_addr.
- redirect_valid  in  1  One-cycle pulse from execute: taken branch/jump.
- redirect_pc  in  32  Target byte address, sampled when redirect_valid=1.
- dec_valid  out  1  Queue head holds a valid instruction.
- dec_instr  out  32  Instruction at queue head.
- dec_pc  out  32  PC of the instruction at queue head.
- dec_ready  in  1  Decode accepts the head this cycle.
- misalign_fault  out  1  Present only with FETCH_MISALIGN_TRAP_EN.

Behaviour:
- Reset (async, any time, including mid-stream):
  - pc=RESET_PC; queue count, read and write pointers cleared.
  - dec_valid=0, dec_instr=0, dec_pc=0, taking effect immediately (not at the next edge).
  - misalign_fault=0.
- Queue signals:
  - pop = dec_valid & dec_ready.
  - full = (count==FIFO_DEPTH).
  - fetch = !full | pop. Simultaneous pop on a full queue still allows a fetch.
- On fetch without redirect:
  - Push {pc, imem_instr}.
  - pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Latency: an instruction at imem_addr in cycle k is on dec_instr/dec_pc with dec_valid=1 in cycle k+1 if the queue was empty.
- Redirect has highest priority:
  - On a cycle with redirect_valid=1: no push; all entries flushed, including any pop that cycle. Decode must treat that cycle's handshake as squashed.
  - pc <= redirect_pc.
  - Next cycle: count=0, dec_valid=0.
  - Target instruction appears at dec_* one cycle after that: redirect in cycle N, target at dec_* in cycle N+2.
- Stall: while dec_valid=1 and dec_ready=0, dec_instr and dec_pc hold stable.
  - The queue keeps filling until full. Then pc holds and imem_addr holds.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
  - Never overflows: push is blocked when full without a pop.
  - Never underflows: pop requires dec_valid.
- Queue storage: entries reset to 0. Output is driven from the head entry (registered), with no combinational path from imem_instr to dec_instr.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN defined:
  - misalign_fault port exists.
  - A redirect with redirect_pc[1:0]!=0 sets misalign_fault=1 in the next cycle and halts fetching (no pushes).
  - The fault clears on a later aligned redirect or on reset.
  - The queue is flushed as for any redirect.
- Undefined:
  - No port.
  - redirect_pc[1:0] is forced to 2'b00 on load and fetch continues.

Decomposition:
- Package riscv_fetch_pkg: XLEN=32, ILEN=32, PC_STEP=4, NOP_INSTR=32'h0000_0013, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: parameterised DEPTH/width, push/pop/flush, count, full/empty, async active-low reset.
- The top level holds the PC register, fetch/redirect control and the optional fault logic.

Test Plan:
- Reset release, dec_ready=1, memory words 0..3 preloaded: imem_addr 0,4,8,12 on consecutive cycles. dec_pc 0,4,8 one cycle behind, with matching dec_instr.
- dec_ready=0 from reset, FIFO_DEPTH=2: two pushes (pc 0, 4), then imem_addr holds at 8. dec_pc stays 0. Raising dec_ready drains 0, 4, 8 back-to-back.
- Redirect to 32'h34 in cycle N with the queue holding 2 entries: dec_valid=0 in N+1. dec_pc=32'h34 with mem[13] in N+2. Old entries are never presented.
- Redirect in the same cycle as a pop on a full queue: no further handshake of the flushed entries. Next dec_pc equals the redirect target.
- rst_n asserted mid-stream with pc=32'h1C: dec_valid drops before the next edge. After release imem_addr=RESET_PC, count=0.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h22: misalign_fault=1 next cycle and no dec_valid. Then redirect to 32'h24: fault clears and fetch resumes at 32'h24.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants: datapath widths, PC increment and the
// {pc, instruction} record carried through the fetch queue.
package riscv_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ILEN      = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Next sequential fetch address; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with push/pop/flush, flush dominating.
// The head entry is read straight from storage, so the read data is always a register.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
    // A pop frees the head slot in the same cycle, so a full queue may still accept a push.
    assign do_push_s = push_i & ~flush_i & (~full_o | do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, fetch/redirect control and the fetch queue toward decode.
// Optional FETCH_MISALIGN_TRAP_EN adds misalign_fault and halts fetch on misaligned redirects.
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_target_s;
    logic         halt_s;
    logic         full_s;
    logic         empty_s;
    logic         pop_s;
    logic         fetch_s;
    logic         push_s;
    fetch_entry_t push_entry_s;
    fetch_entry_t head_entry_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    assign redirect_target_s = redirect_pc;
    assign halt_s            = fault_q;
    assign misalign_fault    = fault_q;

    // Fault flag follows the alignment of the most recent redirect.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            fault_d = fault_q;
        end
    end

    // Fault register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    assign halt_s            = 1'b0;
`endif

    assign imem_addr  = pc_q;
    assign dec_valid  = ~empty_s;
    assign dec_instr  = head_entry_s.instr;
    assign dec_pc     = head_entry_s.pc;
    assign pop_s      = dec_valid & dec_ready;
    assign fetch_s    = ~full_s | pop_s;
    // A redirect squashes both this cycle's fetch and any pop; the queue flushes.
    assign push_s     = fetch_s & ~redirect_valid & ~halt_s;

    assign push_entry_s.pc    = pc_q;
    assign push_entry_s.instr = imem_instr;

    // PC next-state: redirect first, then sequential advance on a push.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target_s;
        end else if (push_s) begin
            pc_d = pc_advance(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .wdata_i (push_entry_s),
        .rdata_o (head_entry_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stall, redirect, wrap,
// mid-stream reset and misaligned redirect handling.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    logic [31:0] imem [0:63];
    int          n_checks = 0;
    int          n_fail   = 0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    assign imem_instr = imem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 + {26'd0, a[7:2]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b(input logic v);
        return {31'd0, v};
    endfunction

    task automatic apply_reset(input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = rdy;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'hC0DE_0000 + i;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        check_eq("rst_valid", b(dec_valid), 32'd0);
        check_eq("rst_instr", dec_instr, 32'd0);
        check_eq("rst_pc", dec_pc, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_fault", b(misalign_fault), 32'd0);
`endif

        // streaming with dec_ready=1
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("stream_addr", imem_addr, 32'(4 * i));
            if (i > 0) begin
                check_eq("stream_valid", b(dec_valid), 32'd1);
                check_eq("stream_pc", dec_pc, 32'(4 * (i - 1)));
                check_eq("stream_instr", dec_instr, word_at(32'(4 * (i - 1))));
            end
            @(negedge clk);
        end

        // stall from reset: queue fills to two, then pc holds
        apply_reset(1'b0);
        check_eq("stall_c0_addr", imem_addr, 32'd0);
        @(negedge clk);
        check_eq("stall_c1_addr", imem_addr, 32'd4);
        check_eq("stall_c1_pc", dec_pc, 32'd0);
        @(negedge clk);
        check_eq("stall_c2_addr", imem_addr, 32'd8);
        check_eq("stall_c2_pc", dec_pc, 32'd0);
        @(negedge clk);
        check_eq("stall_c3_addr", imem_addr, 32'd8);
        check_eq("stall_c3_instr", dec_instr, word_at(32'd0));
        check_eq("stall_c3_valid", b(dec_valid), 32'd1);
        dec_ready = 1'b1;
        @(negedge clk);
        check_eq("drain_pc4", dec_pc, 32'd4);
        check_eq("drain_instr4", dec_instr, word_at(32'd4));
        @(negedge clk);
        check_eq("drain_pc8", dec_pc, 32'd8);
        check_eq("drain_valid8", b(dec_valid), 32'd1);

        // redirect with two queued entries
        apply_reset(1'b0);
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h34;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("redir_n1_valid", b(dec_valid), 32'd0);
        check_eq("redir_n1_addr", imem_addr, 32'h34);
        @(negedge clk);
        check_eq("redir_n2_valid", b(dec_valid), 32'd1);
        check_eq("redir_n2_pc", dec_pc, 32'h34);
        check_eq("redir_n2_instr", dec_instr, imem[13]);

        // redirect with a pop on a full queue, target at the top of memory (wrap)
        @(negedge clk);
        check_eq("popredir_pre_pc", dec_pc, 32'h34);
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("popredir_valid", b(dec_valid), 32'd0);
        check_eq("popredir_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("wrap_pc", dec_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr", dec_instr, imem[63]);
        check_eq("wrap_addr", imem_addr, 32'd0);
        @(negedge clk);
        check_eq("wrap_next_pc", dec_pc, 32'd0);

        // mid-stream reset at pc=0x1C
        apply_reset(1'b1);
        repeat (7) @(negedge clk);
        check_eq("mid_addr", imem_addr, 32'h1C);
        check_eq("mid_pc", dec_pc, 32'h18);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", b(dec_valid), 32'd0);
        check_eq("mid_rst_pc", dec_pc, 32'd0);
        check_eq("mid_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rel_addr", imem_addr, 32'd0);
        check_eq("mid_rel_valid", b(dec_valid), 32'd0);
        @(negedge clk);
        check_eq("mid_after_pc", dec_pc, 32'd0);
        check_eq("mid_after_instr", dec_instr, word_at(32'd0));

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("mis_fault", b(misalign_fault), 32'd1);
        check_eq("mis_valid", b(dec_valid), 32'd0);
        @(negedge clk);
        check_eq("mis_hold_valid", b(dec_valid), 32'd0);
        check_eq("mis_hold_fault", b(misalign_fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h24;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("mis_clear_fault", b(misalign_fault), 32'd0);
        check_eq("mis_clear_addr", imem_addr, 32'h24);
        @(negedge clk);
        check_eq("mis_resume_valid", b(dec_valid), 32'd1);
        check_eq("mis_resume_pc", dec_pc, 32'h24);
`else
        check_eq("align_addr", imem_addr, 32'h20);
        check_eq("align_valid", b(dec_valid), 32'd0);
        @(negedge clk);
        check_eq("align_pc", dec_pc, 32'h20);
        check_eq("align_instr", dec_instr, word_at(32'h20));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
